// File: rtl/bp_fe_bp_update_queue.sv
// Holds issued branch predictions in FIFO order and, as each branch resolves,
// emits a one-cycle predictor update telling whether the prediction was right.
module bp_fe_bp_update_queue #(
    parameter int bht_idx_width_p = 9,
    parameter int depth_p         = 8,
    localparam int ptr_width_lp   = $clog2(depth_p),
    localparam int cnt_width_lp   = $clog2(depth_p) + 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pred_v_i,
    input  logic [bht_idx_width_p-1:0] pred_idx_i,
    input  logic                       pred_taken_i,
    output logic                       pred_ready_o,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic [cnt_width_lp-1:0]    count_o,
    output logic                       underflow_o
);

    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       taken;
    } entry_s;

    entry_s [depth_p-1:0]      mem;
    logic [ptr_width_lp-1:0]   rptr, wptr;
    logic [cnt_width_lp-1:0]   count;
    logic                      enq, deq;
    entry_s                    head;

    assign pred_ready_o = (count != cnt_width_lp'(depth_p));
    assign enq          = pred_v_i & pred_ready_o & ~flush_i;
    assign deq          = res_v_i & (count != '0);
    assign head         = mem[rptr];
    assign count_o      = count;

    // Payloads are don't-care once the pointers are cleared, so no reset here.
    always_ff @(posedge clk_i) begin
        if (enq && !reset_i)
            mem[wptr] <= '{idx: pred_idx_i, taken: pred_taken_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            w_v_o       <= 1'b0;
            idx_w_o     <= '0;
            correct_o   <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            w_v_o <= deq;
            if (deq) begin
                idx_w_o   <= head.idx;
                correct_o <= (head.taken == res_taken_i);
            end
            if (res_v_i && count == '0)
                underflow_o <= 1'b1;
            if (enq)
                wptr <= wptr + 1'b1;
            // Flush never coincides with an enqueue, so wptr is already final.
            if (flush_i) begin
                rptr  <= wptr;
                count <= '0;
            end else begin
                if (deq)
                    rptr <= rptr + 1'b1;
                count <= count + cnt_width_lp'(enq) - cnt_width_lp'(deq);
            end
        end
    end

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Directed bench for the prediction/update queue with hand-derived expectations.
module tb_bp_fe_bp_update_queue;

    localparam int IW = 4;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_i, pred_v_i, pred_taken_i, res_v_i, res_taken_i, flush_i;
    logic [IW-1:0] pred_idx_i;
    logic          pred_ready_o, w_v_o, correct_o, underflow_o;
    logic [IW-1:0] idx_w_o;
    logic [CW-1:0] count_o;

    int checks = 0;
    int failures = 0;

    bp_fe_bp_update_queue #(.bht_idx_width_p(IW), .depth_p(D)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
        .pred_ready_o(pred_ready_o),
        .res_v_i(res_v_i), .res_taken_i(res_taken_i), .flush_i(flush_i),
        .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o),
        .count_o(count_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are stable #1 after the edge on return.
    task automatic cyc(input logic rst, input logic pv, input logic [IW-1:0] pidx,
                       input logic ptk, input logic rv, input logic rtk, input logic fl);
        reset_i = rst; pred_v_i = pv; pred_idx_i = pidx; pred_taken_i = ptk;
        res_v_i = rv; res_taken_i = rtk; flush_i = fl;
        @(posedge clk); #1;
        reset_i = 0; pred_v_i = 0; res_v_i = 0; flush_i = 0;
    endtask

    task automatic enq(input logic [IW-1:0] idx, input logic tk);
        cyc(0, 1, idx, tk, 0, 0, 0);
    endtask

    task automatic res(input logic tk);
        cyc(0, 0, '0, 0, 1, tk, 0);
    endtask

    initial begin
        reset_i = 1; pred_v_i = 0; pred_idx_i = '0; pred_taken_i = 0;
        res_v_i = 0; res_taken_i = 0; flush_i = 0;
        #2;
        cyc(1, 0, '0, 0, 0, 0, 0);
        cyc(1, 0, '0, 0, 0, 0, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ready", pred_ready_o, 1);
        chk("rst_wv", w_v_o, 0);
        chk("rst_idx", idx_w_o, 0);
        chk("rst_corr", correct_o, 0);
        chk("rst_uflow", underflow_o, 0);

        // single mispredicted branch
        enq(4'd5, 1);
        chk("one_count1", count_o, 1);
        res(0);
        chk("one_wv", w_v_o, 1);
        chk("one_idx", idx_w_o, 5);
        chk("one_corr", correct_o, 0);
        chk("one_count0", count_o, 0);
        cyc(0, 0, '0, 0, 0, 0, 0);
        chk("one_wv_drop", w_v_o, 0);
        chk("one_idx_hold", idx_w_o, 5);

        // fill to full from wptr=1 so the pointers wrap
        for (int i = 0; i < D; i++) enq(IW'(i), i[0]);
        chk("full_count", count_o, 8);
        chk("full_ready", pred_ready_o, 0);
        enq(4'd15, 1);
        chk("full_drop_count", count_o, 8);
        for (int i = 0; i < D; i++) begin
            res(1);
            chk("drain_wv", w_v_o, 1);
            chk("drain_idx", idx_w_o, i);
            chk("drain_corr", correct_o, i[0]);
        end
        chk("drain_count", count_o, 0);
        chk("drain_uflow", underflow_o, 0);
        chk("drain_ready", pred_ready_o, 1);

        // simultaneous enqueue and dequeue at count 3
        enq(4'd10, 0); enq(4'd11, 0); enq(4'd12, 0);
        cyc(0, 1, 4'd13, 1, 1, 0, 0);
        chk("sim_count", count_o, 3);
        chk("sim_wv", w_v_o, 1);
        chk("sim_idx", idx_w_o, 10);
        chk("sim_corr", correct_o, 1);
        res(1); chk("sim_idx11", idx_w_o, 11); chk("sim_corr11", correct_o, 0);
        res(1); chk("sim_idx12", idx_w_o, 12); chk("sim_corr12", correct_o, 0);
        res(1); chk("sim_idx13", idx_w_o, 13); chk("sim_corr13", correct_o, 1);
        chk("sim_count0", count_o, 0);

        // flush with coincident resolve and a refused enqueue
        enq(4'd1, 1); enq(4'd2, 1); enq(4'd3, 1); enq(4'd4, 1);
        chk("fl_count4", count_o, 4);
        cyc(0, 1, 4'd9, 0, 1, 1, 1);
        chk("fl_wv", w_v_o, 1);
        chk("fl_idx", idx_w_o, 1);
        chk("fl_corr", correct_o, 1);
        chk("fl_count", count_o, 0);
        res(1);
        chk("uf_wv", w_v_o, 0);
        chk("uf_flag", underflow_o, 1);
        chk("uf_count", count_o, 0);
        cyc(0, 0, '0, 0, 0, 0, 0);
        chk("uf_sticky", underflow_o, 1);
        // queue usable after flush: new entry comes out first
        enq(4'd6, 0);
        res(0);
        chk("post_fl_idx", idx_w_o, 6);
        chk("post_fl_corr", correct_o, 1);

        // reset beats a coincident resolve
        for (int i = 0; i < 5; i++) enq(IW'(i + 8), 1);
        chk("rr_count5", count_o, 5);
        cyc(1, 0, '0, 0, 1, 1, 0);
        chk("rr_count", count_o, 0);
        chk("rr_wv", w_v_o, 0);
        chk("rr_uflow", underflow_o, 0);
        chk("rr_ready", pred_ready_o, 1);
        chk("rr_idx", idx_w_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
